// File: rtl/quad_sweep_pkg.sv
// -----------------------------------------------------------------------------
// quad_sweep_pkg
//   Shared definitions for the quadratic-solver sweep controller: the FSM state
//   encoding and the default x / result widths, which the solver also uses.
// -----------------------------------------------------------------------------
package quad_sweep_pkg;

    localparam int XW_DEF      = 8;   // width of x, signed
    localparam int RW_DEF      = 16;  // width of solver result, signed
    localparam int TIMEOUT_DEF = 32;  // enable-to-valid budget in cycles
    localparam int CW_DEF      = 9;   // point counter width

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ISSUE   = 3'd1,
        ST_WAIT    = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_NEXT    = 3'd4,
        ST_ABORT   = 3'd5,
        ST_DONE    = 3'd6
    } state_t;

endpackage

// File: rtl/quad_sweep_stats.sv
// -----------------------------------------------------------------------------
// quad_sweep_stats
//   Running statistics over the captured solver results.
//   Ports:
//     clock, reset      clock and synchronous active-high reset
//     clear_i           zero all statistics (new sweep accepted)
//     capture_i         fold result_i / x_i into the statistics
//     result_i, x_i     captured result and the x that produced it (signed)
//     res_min_o/max_o   running signed extremes
//     x_at_min_o/max_o  x of each extreme; first occurrence wins ties
//     points_o          captures so far, saturating at all-ones
// -----------------------------------------------------------------------------
module quad_sweep_stats
    import quad_sweep_pkg::*;
#(
    parameter int XW = XW_DEF,
    parameter int RW = RW_DEF,
    parameter int CW = CW_DEF
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          clear_i,
    input  logic          capture_i,
    input  logic [RW-1:0] result_i,
    input  logic [XW-1:0] x_i,
    output logic [RW-1:0] res_min_o,
    output logic [RW-1:0] res_max_o,
    output logic [XW-1:0] x_at_min_o,
    output logic [XW-1:0] x_at_max_o,
    output logic [CW-1:0] points_o
);

    logic [RW-1:0] min_q, max_q;
    logic [XW-1:0] xmin_q, xmax_q;
    logic [CW-1:0] points_q;

    always_ff @(posedge clock) begin
        if (reset || clear_i) begin
            min_q    <= '0;
            max_q    <= '0;
            xmin_q   <= '0;
            xmax_q   <= '0;
            points_q <= '0;
        end else if (capture_i) begin
            // points_q == 0 marks the first capture of the sweep.
            if (points_q == '0) begin
                min_q  <= result_i;
                max_q  <= result_i;
                xmin_q <= x_i;
                xmax_q <= x_i;
            end else begin
                // Strict compares so the earliest x is kept on ties.
                if ($signed(result_i) < $signed(min_q)) begin
                    min_q  <= result_i;
                    xmin_q <= x_i;
                end
                if ($signed(result_i) > $signed(max_q)) begin
                    max_q  <= result_i;
                    xmax_q <= x_i;
                end
            end
            if (points_q != '1) begin
                points_q <= points_q + CW'(1);
            end
        end
    end

    assign res_min_o  = min_q;
    assign res_max_o  = max_q;
    assign x_at_min_o = xmin_q;
    assign x_at_max_o = xmax_q;
    assign points_o   = points_q;

endmodule

// File: rtl/quad_sweep_controller.sv
// -----------------------------------------------------------------------------
// quad_sweep_controller
//   Steps x from x_start to x_end (inclusive) by x_step and hands each point
//   to the quadratic solver, collecting min/max/argmin/argmax/count.
//   Ports:
//     clock, reset              clock; synchronous active-high reset
//     start                     1-cycle request, accepted only in IDLE
//     x_start, x_end, x_step    sweep range (signed) and unsigned step (0 => 1)
//     solver_ready/valid/result solver handshake inputs
//     solver_x, solver_enable   point presented to solver and 1-cycle kick
//     busy, done, timeout_err   sweep status; timeout_err is sticky
//     res_min/res_max, x_at_min/x_at_max, points   sweep statistics
//   Handshake: solver_enable pulses for exactly one cycle, only in ISSUE and
//   only while solver_ready is high; solver_x stays stable from ISSUE until
//   the result is captured; solver_valid is honoured only in WAIT.
// -----------------------------------------------------------------------------
module quad_sweep_controller
    import quad_sweep_pkg::*;
#(
    parameter int XW      = XW_DEF,
    parameter int RW      = RW_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF,
    parameter int CW      = CW_DEF
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          start,
    input  logic [XW-1:0] x_start,
    input  logic [XW-1:0] x_end,
    input  logic [XW-1:0] x_step,
    input  logic          solver_ready,
    input  logic          solver_valid,
    input  logic [RW-1:0] solver_result,
    output logic [XW-1:0] solver_x,
    output logic          solver_enable,
    output logic          busy,
    output logic          done,
    output logic          timeout_err,
    output logic [RW-1:0] res_min,
    output logic [RW-1:0] res_max,
    output logic [XW-1:0] x_at_min,
    output logic [XW-1:0] x_at_max,
    output logic [CW-1:0] points
);

    localparam int TW = $clog2(TIMEOUT + 1);
    // Largest positive x, extended by one bit for the overflow-safe compare.
    localparam logic signed [XW:0] X_MAX = {2'b00, {(XW-1){1'b1}}};

    state_t        state_q, state_d;
    logic [XW-1:0] x_q, x_end_q, step_q;
    logic [RW-1:0] result_q;
    logic [TW-1:0] timer_q;
    logic          timeout_err_q;

    logic              start_acc;
    logic              capture;
    logic              more;
    logic signed [XW:0] next_sum;

    // Next x in XW+1 bits so a step past +127 is seen as "past the end"
    // instead of wrapping negative.
    assign next_sum = $signed({x_q[XW-1], x_q}) + $signed({1'b0, step_q});
    assign more     = (next_sum <= $signed({x_end_q[XW-1], x_end_q})) &&
                      (next_sum <= X_MAX);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        solver_enable = 1'b0;
        start_acc     = 1'b0;
        capture       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    start_acc = 1'b1;
                    state_d   = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (solver_ready) begin
                    solver_enable = 1'b1;
                    state_d       = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (solver_valid) begin
                    state_d = ST_CAPTURE;
                end else if (timer_q == TW'(TIMEOUT)) begin
                    state_d = ST_ABORT;
                end
            end
            ST_CAPTURE: begin
                capture = 1'b1;
                state_d = ST_NEXT;
            end
            ST_NEXT:  state_d = more ? ST_ISSUE : ST_DONE;
            ST_ABORT: state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            x_q           <= '0;
            x_end_q       <= '0;
            step_q        <= '0;
            result_q      <= '0;
            timer_q       <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            if (start_acc) begin
                x_q           <= x_start;
                x_end_q       <= x_end;
                step_q        <= (x_step == '0) ? XW'(1) : x_step;
                timeout_err_q <= 1'b0;
            end
            if (state_q == ST_NEXT && more) begin
                x_q <= next_sum[XW-1:0];
            end
            // Timer is zero on every entry into WAIT because it is held
            // cleared in all other states.
            if (state_q == ST_WAIT) begin
                timer_q <= timer_q + TW'(1);
            end else begin
                timer_q <= '0;
            end
            // solver_valid is a single-cycle strobe; hold the result for CAPTURE.
            if (state_q == ST_WAIT && solver_valid) begin
                result_q <= solver_result;
            end
            if (state_q == ST_ABORT) begin
                timeout_err_q <= 1'b1;
            end
        end
    end

    quad_sweep_stats #(
        .XW (XW),
        .RW (RW),
        .CW (CW)
    ) u_stats (
        .clock      (clock),
        .reset      (reset),
        .clear_i    (start_acc),
        .capture_i  (capture),
        .result_i   (result_q),
        .x_i        (x_q),
        .res_min_o  (res_min),
        .res_max_o  (res_max),
        .x_at_min_o (x_at_min),
        .x_at_max_o (x_at_max),
        .points_o   (points)
    );

    assign solver_x    = x_q;
    assign busy        = (state_q != ST_IDLE) && (state_q != ST_DONE);
    assign done        = (state_q == ST_DONE);
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_quad_sweep_controller.sv
module tb_quad_sweep_controller;
  localparam int XW = 8;
  localparam int RW = 16;
  localparam int TIMEOUT = 32;
  localparam int CW = 9;
  localparam int LAT = 16;

  // clock / reset
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic          start = 1'b0;
  logic [XW-1:0] x_start = '0, x_end = '0, x_step = '0;
  logic          solver_ready;
  logic          solver_valid = 1'b0;
  logic [RW-1:0] solver_result = '0;
  logic [XW-1:0] solver_x;
  logic          solver_enable, busy, done, timeout_err;
  logic [RW-1:0] res_min, res_max;
  logic [XW-1:0] x_at_min, x_at_max;
  logic [CW-1:0] points;

  int pass_cnt = 0;
  int total_cnt = 0;

  quad_sweep_controller #(.XW(XW), .RW(RW), .TIMEOUT(TIMEOUT), .CW(CW)) dut (
    .clock(clock), .reset(reset), .start(start),
    .x_start(x_start), .x_end(x_end), .x_step(x_step),
    .solver_ready(solver_ready), .solver_valid(solver_valid), .solver_result(solver_result),
    .solver_x(solver_x), .solver_enable(solver_enable), .busy(busy), .done(done),
    .timeout_err(timeout_err), .res_min(res_min), .res_max(res_max),
    .x_at_min(x_at_min), .x_at_max(x_at_max), .points(points)
  );

  // behavioural solver: fixed latency, ready whenever idle
  int coef_a = 0, coef_b = 0, coef_c = 0;
  bit never_valid = 1'b0;
  bit m_busy = 1'b0;
  int m_cnt = 0;
  logic [XW-1:0] m_x = '0;
  logic [XW-1:0] obs_q[$];
  logic [XW-1:0] exp_q[$];

  assign solver_ready = ~m_busy;

  function automatic int quad(input logic [XW-1:0] xv);
    int xi;
    xi = $signed(xv);
    return coef_a * xi * xi + coef_b * xi + coef_c;
  endfunction

  always @(posedge clock) begin
    if (reset) begin
      m_busy <= 1'b0;
      m_cnt <= 0;
      solver_valid <= 1'b0;
    end else begin
      solver_valid <= 1'b0;
      if (!m_busy && solver_enable) begin
        m_busy <= 1'b1;
        m_cnt <= LAT;
        m_x <= solver_x;
        obs_q.push_back(solver_x);
      end else if (m_busy) begin
        if (m_cnt == 1) begin
          m_busy <= 1'b0;
          if (!never_valid) begin
            solver_valid <= 1'b1;
            solver_result <= RW'(quad(m_x));
          end
        end else begin
          m_cnt <= m_cnt - 1;
        end
      end
    end
  end

  // reference: list of x values visited by the sweep, from plain arithmetic
  function automatic void build_exp(input int xs, input int xe, input int st);
    int x, s;
    exp_q.delete();
    s = (st == 0) ? 1 : st;
    x = xs;
    exp_q.push_back(XW'(x));
    while (x + s <= xe && x + s <= 127) begin
      x = x + s;
      exp_q.push_back(XW'(x));
    end
  endfunction

  // driver: pulse start, run until done (+5 cycles) or budget expires
  task automatic start_and_wait(input int xs, input int xe, input int st, input int restart_at,
                                output int done_cnt, output int en_cyc, output int done_cyc);
    int cyc;
    done_cnt = 0; en_cyc = -1; done_cyc = -1; cyc = 0;
    obs_q.delete();
    @(negedge clock);
    x_start = XW'(xs); x_end = XW'(xe); x_step = XW'(st); start = 1'b1;
    while (cyc < 4000 && (done_cyc < 0 || cyc < done_cyc + 5)) begin
      @(negedge clock);
      cyc++;
      start = (restart_at != 0 && cyc == restart_at);
      if (start) begin
        x_start = 8'd100; x_end = 8'd120; x_step = 8'd1;
      end
      if (solver_enable && en_cyc < 0) en_cyc = cyc;
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc;
      end
    end
  endtask

  task automatic run_sweep(input string name, input int xs, input int xe, input int st,
                           input int a, input int b, input int c, input int restart_at);
    int dcnt, en_cyc, done_cyc, rv, emin, emax, n;
    logic signed [RW-1:0] rt;
    logic [XW-1:0] exmin, exmax;
    bit seq_ok;
    coef_a = a; coef_b = b; coef_c = c; never_valid = 1'b0;
    build_exp(xs, xe, st);
    n = exp_q.size();
    emin = 0; emax = 0; exmin = '0; exmax = '0;
    for (int i = 0; i < n; i++) begin
      rt = RW'(quad(exp_q[i]));
      rv = rt;
      if (i == 0 || rv < emin) begin emin = rv; exmin = exp_q[i]; end
      if (i == 0 || rv > emax) begin emax = rv; exmax = exp_q[i]; end
    end
    start_and_wait(xs, xe, st, restart_at, dcnt, en_cyc, done_cyc);
    total_cnt++;
    if (dcnt !== 1) $display("FAIL %s done_pulses got=%0d exp=1", name, dcnt); else pass_cnt++;
    total_cnt++;
    if (points !== CW'(n)) $display("FAIL %s points got=%0d exp=%0d", name, points, n); else pass_cnt++;
    total_cnt++;
    if (res_min !== RW'(emin)) $display("FAIL %s res_min got=%0d exp=%0d", name, $signed(res_min), emin); else pass_cnt++;
    total_cnt++;
    if (res_max !== RW'(emax)) $display("FAIL %s res_max got=%0d exp=%0d", name, $signed(res_max), emax); else pass_cnt++;
    total_cnt++;
    if (x_at_min !== exmin) $display("FAIL %s x_at_min got=%0d exp=%0d", name, $signed(x_at_min), $signed(exmin)); else pass_cnt++;
    total_cnt++;
    if (x_at_max !== exmax) $display("FAIL %s x_at_max got=%0d exp=%0d", name, $signed(x_at_max), $signed(exmax)); else pass_cnt++;
    total_cnt++;
    if (busy !== 1'b0 || timeout_err !== 1'b0)
      $display("FAIL %s busy/timeout_err got=%b/%b exp=0/0", name, busy, timeout_err);
    else pass_cnt++;
    seq_ok = (obs_q.size() == n);
    for (int i = 0; i < n && seq_ok; i++) if (obs_q[i] !== exp_q[i]) seq_ok = 1'b0;
    total_cnt++;
    if (!seq_ok) $display("FAIL %s x_sequence got_len=%0d exp_len=%0d", name, obs_q.size(), n); else pass_cnt++;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0;
    repeat (3) @(negedge clock);
    total_cnt++;
    if ({busy, done, solver_enable, timeout_err} !== 4'b0)
      $display("FAIL reset_ctrl got=%b exp=0000", {busy, done, solver_enable, timeout_err});
    else pass_cnt++;
    total_cnt++;
    if ({res_min, res_max, x_at_min, x_at_max, points, solver_x} !== '0)
      $display("FAIL reset_data got=%h exp=0", {res_min, res_max, x_at_min, x_at_max, points, solver_x});
    else pass_cnt++;
    reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_timeout();
    int dcnt, en_cyc, done_cyc;
    coef_a = 1; coef_b = 0; coef_c = 0; never_valid = 1'b1;
    start_and_wait(0, 3, 1, 0, dcnt, en_cyc, done_cyc);
    total_cnt++;
    if (dcnt !== 1) $display("FAIL timeout done_pulses got=%0d exp=1", dcnt); else pass_cnt++;
    total_cnt++;
    if (timeout_err !== 1'b1) $display("FAIL timeout_err got=%b exp=1", timeout_err); else pass_cnt++;
    total_cnt++;
    if (busy !== 1'b0 || points !== '0) $display("FAIL timeout busy/points got=%b/%0d exp=0/0", busy, points); else pass_cnt++;
    total_cnt++;
    if (en_cyc < 0 || done_cyc - en_cyc < TIMEOUT || done_cyc - en_cyc > TIMEOUT + 4)
      $display("FAIL timeout_delay got=%0d exp=%0d..%0d", done_cyc - en_cyc, TIMEOUT, TIMEOUT + 4);
    else pass_cnt++;
    never_valid = 1'b0;
    repeat (LAT + 2) @(negedge clock);
  endtask

  task automatic test_reset_mid();
    int cyc, dcnt;
    coef_a = 1; coef_b = 0; coef_c = -4; never_valid = 1'b0;
    obs_q.delete();
    @(negedge clock);
    x_start = 8'd0; x_end = 8'd3; x_step = 8'd1; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    cyc = 0;
    while (obs_q.size() < 2 && cyc < 200) begin @(negedge clock); cyc++; end
    repeat (3) @(negedge clock);
    total_cnt++;
    if (points !== CW'(1) || busy !== 1'b1) $display("FAIL mid_pre points/busy got=%0d/%b exp=1/1", points, busy); else pass_cnt++;
    reset = 1'b1;
    @(negedge clock);
    total_cnt++;
    if ({busy, done, solver_enable, timeout_err, res_min, res_max, x_at_min, x_at_max, points, solver_x} !== '0)
      $display("FAIL mid_reset_outputs got=%h exp=0",
               {busy, done, solver_enable, timeout_err, res_min, res_max, x_at_min, x_at_max, points, solver_x});
    else pass_cnt++;
    reset = 1'b0;
    dcnt = 0;
    repeat (60) begin @(negedge clock); if (done || busy) dcnt++; end
    total_cnt++;
    if (dcnt !== 0) $display("FAIL mid_no_done got=%0d exp=0", dcnt); else pass_cnt++;
  endtask

  task automatic test_random();
    int xs, xe, st;
    for (int k = 0; k < 8; k++) begin
      xs = int'($urandom_range(0, 255)) - 128;
      if ($urandom_range(0, 5) == 0) begin
        xe = xs - 1 - int'($urandom_range(0, 20));
        if (xe < -128) xe = -128;
      end else begin
        xe = xs + int'($urandom_range(0, 24));
        if (xe > 127) xe = 127;
      end
      st = $urandom_range(0, 6);
      run_sweep($sformatf("random%0d", k), xs, xe, st,
                int'($urandom_range(0, 2)) - 1, int'($urandom_range(0, 6)) - 3,
                int'($urandom_range(0, 100)) - 50, 0);
    end
  endtask

  initial begin
    test_reset();
    run_sweep("basic", 0, 3, 1, 1, 0, -4, 0);
    run_sweep("tie", -3, 3, 3, 1, 0, 0, 0);
    run_sweep("upper_edge", 120, 127, 5, 1, 0, 0, 0);
    run_sweep("reverse", 10, -5, 2, 1, 2, 3, 0);
    test_timeout();
    run_sweep("after_timeout", -2, 2, 1, -1, 1, 7, 0);
    test_reset_mid();
    run_sweep("busy_start_step0", 5, 7, 0, 1, -3, 2, 12);
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
